// File: rtl/immediate_field_encoder.sv
// immediate_field_encoder
// Packs a 32-bit immediate or branch target into the simm13 / simm7 /
// disp22 / disp30 field of a SPARC-format instruction template. Two-stage
// valid/ready pipeline: stage 1 computes field + range/alignment flags,
// stage 2 merges the field into the template. Both stages advance on a
// single enable, so bubbles are kept and throughput is one word per cycle.
// Optional build macro: ERR_DROP_EN -- when defined, words with any error are
// dropped at stage 2 (counted at load time) instead of being delivered.
module immediate_field_encoder #(
   parameter int CNT_W  = 8,
   parameter bit PC_REL = 1'b1
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [1:0]       Kind,
   input  logic [31:0]      Value,
   input  logic [31:0]      Pc,
   input  logic [31:0]      Base,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [31:0]      Word,
   output logic             Range_Err,
   output logic             Align_Err,
   output logic [CNT_W-1:0] Err_Count
);

   localparam logic [1:0] K_SIMM13 = 2'b00;
   localparam logic [1:0] K_SIMM7  = 2'b01;
   localparam logic [1:0] K_DISP22 = 2'b10;
   localparam logic [1:0] K_DISP30 = 2'b11;

   // True when every bit of the slice is identical (sign-extension check).
   function automatic logic all_same(input logic [25:0] bits, input logic [25:0] mask);
      all_same = ((bits & mask) == 26'd0) || ((bits & mask) == mask);
   endfunction

   logic        en_s;
   logic [31:0] delta_s;
   logic [29:0] field_s;
   logic        range_s;
   logic        align_s;

   logic        s1_valid_q;
   logic [1:0]  s1_kind_q;
   logic [29:0] s1_field_q;
   logic        s1_range_q;
   logic        s1_align_q;
   logic [31:0] s1_base_q;

   logic        out_valid_q, out_valid_d;
   logic [31:0] word_q, word_d;
   logic        range_q, range_d;
   logic        align_q, align_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        cnt_inc_s;
   logic        s1_err_s;

   // Template bits that every kind overwrites or leaves to the caller.
   logic unused_base_s;
   assign unused_base_s = ^{s1_base_q[13], s1_base_q[6:0]};

   assign en_s     = Out_Ready || !out_valid_q;
   assign In_Ready = en_s;
   assign s1_err_s = s1_range_q || s1_align_q;

   // Stage 1: offset calculation, field extraction and range/alignment flags.
   always_comb begin
      delta_s = Value;
      field_s = 30'd0;
      range_s = 1'b0;
      align_s = 1'b0;
      if (PC_REL && Kind[1]) begin
         delta_s = Value - Pc;
      end else begin
         delta_s = Value;
      end
      case (Kind)
         K_SIMM13: begin
            field_s = {17'd0, Value[12:0]};
            range_s = !all_same({6'd0, Value[31:12]}, 26'h00FFFFF);
         end
         K_SIMM7: begin
            field_s = {23'd0, Value[6:0]};
            range_s = !all_same(Value[31:6], 26'h3FFFFFF);
         end
         K_DISP22: begin
            field_s = {8'd0, delta_s[23:2]};
            range_s = !all_same({17'd0, delta_s[31:23]}, 26'h00001FF);
            align_s = (delta_s[1:0] != 2'b00);
         end
         K_DISP30: begin
            field_s = delta_s[31:2];
            align_s = (delta_s[1:0] != 2'b00);
         end
         default: begin
            field_s = 30'd0;
         end
      endcase
   end

   // Stage 1 register: capture computed field, flags and template.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_valid_q <= 1'b0;
         s1_kind_q  <= 2'b00;
         s1_field_q <= 30'd0;
         s1_range_q <= 1'b0;
         s1_align_q <= 1'b0;
         s1_base_q  <= 32'd0;
      end else if (en_s) begin
         s1_valid_q <= In_Valid;
         s1_kind_q  <= Kind;
         s1_field_q <= field_s;
         s1_range_q <= range_s;
         s1_align_q <= align_s;
         s1_base_q  <= Base;
      end
   end

   // Stage 2: merge field into template and decide output valid / error count.
   always_comb begin
      word_d = s1_base_q;
      case (s1_kind_q)
         K_SIMM13: word_d = {s1_base_q[31:14], 1'b1, s1_field_q[12:0]};
         K_SIMM7:  word_d = {s1_base_q[31:14], 1'b1, s1_base_q[12:7], s1_field_q[6:0]};
         K_DISP22: word_d = {s1_base_q[31:22], s1_field_q[21:0]};
         K_DISP30: word_d = {s1_base_q[31:30], s1_field_q};
         default:  word_d = s1_base_q;
      endcase
      range_d = s1_valid_q && s1_range_q;
      align_d = s1_valid_q && s1_align_q;
`ifdef ERR_DROP_EN
      out_valid_d = s1_valid_q && !s1_err_s;
      cnt_inc_s   = en_s && s1_valid_q && s1_err_s;
`else
      out_valid_d = s1_valid_q;
      cnt_inc_s   = out_valid_q && Out_Ready && (range_q || align_q);
`endif
      if (cnt_inc_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Stage 2 register: output word and flags hold while stalled.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         out_valid_q <= 1'b0;
         word_q      <= 32'd0;
         range_q     <= 1'b0;
         align_q     <= 1'b0;
      end else if (en_s) begin
         out_valid_q <= out_valid_d;
         word_q      <= word_d;
         range_q     <= range_d;
         align_q     <= align_d;
      end
   end

   // Saturating count of erroneous words.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign Out_Valid = out_valid_q;
   assign Word      = word_q;
   assign Range_Err = range_q;
   assign Align_Err = align_q;
   assign Err_Count = cnt_q;

endmodule

// File: tb/tb_immediate_field_encoder.sv
// Directed self-checking bench for immediate_field_encoder (default build).
module tb_immediate_field_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  kind;
   logic [31:0] value;
   logic [31:0] pc;
   logic [31:0] base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] word;
   logic        range_err;
   logic        align_err;
   logic [7:0]  err_count;

   int errors;
   int checks;
   int exp_cnt;

   immediate_field_encoder #(.CNT_W(8), .PC_REL(1'b1)) dut (
      .Clk(clk), .Reset_n(rst_n), .In_Valid(in_valid), .In_Ready(in_ready),
      .Kind(kind), .Value(value), .Pc(pc), .Base(base),
      .Out_Valid(out_valid), .Out_Ready(out_ready), .Word(word),
      .Range_Err(range_err), .Align_Err(align_err), .Err_Count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single request through an idle pipeline; returns result and latency.
   task automatic do_req(input logic [1:0] k, input logic [31:0] v, input logic [31:0] p,
                         input logic [31:0] b, output logic [31:0] w, output logic re,
                         output logic ae, output int lat);
      @(negedge clk);
      in_valid = 1'b1; kind = k; value = v; pc = p; base = b;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      w = word; re = range_err; ae = align_err;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      kind = 2'b00; value = 32'd0; pc = 32'd0; base = 32'd0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || word !== 32'd0 || range_err !== 1'b0 ||
          align_err !== 1'b0 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: ov=%b word=%h re=%b ae=%b cnt=%0d, required 0 0 0 0 0",
                  out_valid, word, range_err, align_err, err_count);
      end
      @(negedge clk); rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      exp_cnt = 0;
   endtask

   // Generic vector check used by the per-kind tasks below.
   task automatic test_kind(input string name, input logic [1:0] k, input logic [31:0] v,
                            input logic [31:0] p, input logic [31:0] b, input logic [31:0] ew,
                            input logic ere, input logic eae);
      logic [31:0] w; logic re; logic ae; int lat;
      do_req(k, v, p, b, w, re, ae, lat);
      if (ere || eae) exp_cnt++;
      checks++;
      if (w !== ew || re !== ere || ae !== eae || lat !== 2) begin
         errors++;
         $display("FAIL %s: word=%h re=%b ae=%b lat=%0d required word=%h re=%b ae=%b lat=2",
                  name, w, re, ae, lat, ew, ere, eae);
      end
      checks++;
      if (err_count !== 8'(exp_cnt)) begin
         errors++;
         $display("FAIL %s_cnt: err_count=%0d required %0d", name, err_count, exp_cnt);
      end
   endtask

   task automatic test_simm13();
      test_kind("simm13_fit",  2'b00, 32'hFFFFF000, 32'h0, 32'h82000000, 32'h82003000, 1'b0, 1'b0);
      test_kind("simm13_rng",  2'b00, 32'h00001000, 32'h0, 32'h82000000, 32'h82003000, 1'b1, 1'b0);
   endtask

   task automatic test_disp22();
      test_kind("disp22_neg",  2'b10, 32'h00000FF0, 32'h1000, 32'h10800000, 32'h10BFFFFC, 1'b0, 1'b0);
      test_kind("disp22_rng",  2'b10, 32'h00801000, 32'h1000, 32'h10800000, 32'h10A00000, 1'b1, 1'b0);
   endtask

   task automatic test_disp30();
      test_kind("disp30_ok",   2'b11, 32'h00000040, 32'h0, 32'h40000000, 32'h40000010, 1'b0, 1'b0);
      test_kind("disp30_aln",  2'b11, 32'h00000102, 32'h0, 32'h40000000, 32'h40000040, 1'b0, 1'b1);
   endtask

   task automatic test_simm7();
      test_kind("simm7_max",   2'b01, 32'h0000003F, 32'h0, 32'h81800000, 32'h8180203F, 1'b0, 1'b0);
      test_kind("simm7_rng",   2'b01, 32'h00000040, 32'h0, 32'h81800000, 32'h81802040, 1'b1, 1'b0);
      test_kind("simm7_neg",   2'b01, 32'hFFFFFFC0, 32'h0, 32'h81801F80, 32'h81803FC0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [4];
      logic [31:0] got [$];
      logic [31:0] held;
      logic        prev_stall;
      int          idx;
      exp_w[0] = 32'h82002001; exp_w[1] = 32'h82002002;
      exp_w[2] = 32'h82002003; exp_w[3] = 32'h82002004;
      idx = 0; prev_stall = 1'b0; held = 32'd0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 3 && cyc <= 5) ? 1'b0 : 1'b1;
         in_valid  = (idx < 4);
         kind = 2'b00; pc = 32'd0; base = 32'h82000000;
         value = 32'(idx + 1);
         #1;
         if (prev_stall) begin
            checks++;
            if (word !== held || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold: word=%h ov=%b required word=%h ov=1", word, out_valid, held);
            end
         end
         if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_in_ready: got %b required 0", in_ready);
            end
            held = word; prev_stall = 1'b1;
         end else begin
            prev_stall = 1'b0;
         end
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) got.push_back(word);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (got.size() !== 4) begin
         errors++;
         $display("FAIL bp_count: delivered %0d required 4", got.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= got.size() || got[i] !== exp_w[i]) begin
            errors++;
            $display("FAIL bp_order_%0d: word=%h required %h", i,
                     (i < got.size()) ? got[i] : 32'hDEADDEAD, exp_w[i]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; kind = 2'b00; value = 32'h00001000; base = 32'h82000000;
      end
      #1;
      checks++;
      if (out_valid !== 1'b1 || err_count === 8'd0) begin
         errors++;
         $display("FAIL pre_reset: ov=%b cnt=%0d required ov=1 cnt>0", out_valid, err_count);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL midstream_reset: ov=%b cnt=%0d required 0 0", out_valid, err_count);
      end
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushed_%0d: ov=%b required 0", i, out_valid);
         end
      end
      exp_cnt = 0;
   endtask

   task automatic test_saturation();
      int delivered;
      int not_ready;
      delivered = 0; not_ready = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 304; i++) begin
         @(negedge clk);
         in_valid = (i < 300);
         kind = 2'b01; value = 32'h00000040; base = 32'h81800000; pc = 32'd0;
         #1;
         if (!in_ready) not_ready++;
         if (out_valid) delivered++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (delivered !== 300 || not_ready !== 0) begin
         errors++;
         $display("FAIL throughput: delivered=%0d stalls=%0d required 300 0", delivered, not_ready);
      end
      checks++;
      if (err_count !== 8'd255) begin
         errors++;
         $display("FAIL saturation: err_count=%0d required 255", err_count);
      end
   endtask

   initial begin
      errors = 0; checks = 0; exp_cnt = 0;
      test_reset();
      test_simm13();
      test_disp22();
      test_disp30();
      test_simm7();
      test_back_to_back();
      test_reset_midstream();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
